// File: rtl/picomips_pkg.sv
// picomips_pkg: definitions shared by the picoMips fetch/decode blocks.
// Holds the instruction field widths, the opcode map, the datapath control
// enums, the fetch FSM state type and the decoded control bundle.
package picomips_pkg;

  localparam int OPCODE_W = 6;
  localparam int IMM_W    = 4;
  localparam int INSTR_W  = OPCODE_W + IMM_W;

  // Opcode map (Instruction[9:4]). Any value not listed here is illegal.
  localparam logic [OPCODE_W-1:0] OP_LS   = 6'd1;  // acc <- switches
  localparam logic [OPCODE_W-1:0] OP_LR   = 6'd2;  // acc <- reg
  localparam logic [OPCODE_W-1:0] OP_AR   = 6'd3;  // reg <- acc
  localparam logic [OPCODE_W-1:0] OP_ADDI = 6'd4;  // acc <- acc + imm
  localparam logic [OPCODE_W-1:0] OP_ADDR = 6'd5;  // acc <- acc + reg
  localparam logic [OPCODE_W-1:0] OP_MULI = 6'd6;  // acc <- acc * imm
  localparam logic [OPCODE_W-1:0] OP_HEI  = 6'd7;  // wait while SW8 == imm[0]

  typedef enum logic [1:0] {
    SRC_SW  = 2'd0,
    SRC_REG = 2'd1,
    SRC_ALU = 2'd2
  } acc_src_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_MUL  = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    acc_src_t acc_src;
    alu_op_t  alu_op;
    logic     alu_b_imm;
    logic     acc_we;
    logic     reg_we;
  } ctrl_t;

  // Bundle value that performs no write; also the idle value on the outputs.
  localparam ctrl_t CTRL_NOP = '{
    acc_src:   SRC_SW,
    alu_op:    ALU_PASS,
    alu_b_imm: 1'b0,
    acc_we:    1'b0,
    reg_we:    1'b0
  };

endpackage

// File: rtl/fetch_decode_if.sv
// fetch_decode_if: program memory bus between fetch_decode and the ROM.
//   Addr        : word address, driven by the fetch unit (master).
//   Instruction : registered ROM data, valid one cycle after Addr.
// The bus has no handshake: the ROM answers every address with a fixed
// one-cycle latency, so there is no valid/ready pair on it.
interface fetch_decode_if #(
  parameter int PC_WIDTH = 5
);
  import picomips_pkg::*;

  logic [PC_WIDTH-1:0] Addr;
  logic [INSTR_W-1:0]  Instruction;

  modport master (
    output Addr,
    input  Instruction
  );

  modport slave (
    input  Addr,
    output Instruction
  );

endinterface

// File: rtl/instruction_decoder.sv
// instruction_decoder: purely combinational opcode decode.
//   opcode  : Instruction[9:4]
//   ctrl    : datapath control bundle (source, ALU op, B select, write enables)
//   illegal : opcode is not in the opcode map
// Outputs are not qualified here; the fetch unit gates them with valid.
module instruction_decoder
  import picomips_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_LS: begin
        ctrl.acc_we  = 1'b1;
        ctrl.acc_src = SRC_SW;
      end
      OP_LR: begin
        ctrl.acc_we  = 1'b1;
        ctrl.acc_src = SRC_REG;
      end
      OP_AR: begin
        ctrl.reg_we = 1'b1;
      end
      OP_ADDI: begin
        ctrl.acc_we    = 1'b1;
        ctrl.acc_src   = SRC_ALU;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_b_imm = 1'b1;
      end
      OP_ADDR: begin
        ctrl.acc_we    = 1'b1;
        ctrl.acc_src   = SRC_ALU;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_b_imm = 1'b0;
      end
      OP_MULI: begin
        ctrl.acc_we    = 1'b1;
        ctrl.acc_src   = SRC_ALU;
        ctrl.alu_op    = ALU_MUL;
        ctrl.alu_b_imm = 1'b1;
      end
      OP_HEI: begin
        // No writes; the stall decision lives in the fetch FSM.
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: picoMips instruction fetch and decode.
// Walks the program counter over the synchronous program memory, inserts one
// FILL bubble after reset, stalls on OP_HEI until SW8 leaves the level given
// by imm[0], and decodes the returned instruction into datapath controls.
//   Clock, Reset : clock and synchronous active-high reset
//   pmem         : program memory bus (Addr out, Instruction in)
//   SW8          : wait switch, already synchronised
//   valid        : decode outputs describe an instruction executing this cycle.
//                  There is no ready: the datapath consumes every valid cycle.
//   exec_addr    : address of the executing instruction
//   imm, reg_sel : raw immediate and its bit 0 (register select)
//   acc_src, alu_op, alu_b_imm, acc_we, reg_we, illegal : decoded controls,
//                  forced to SRC_SW/ALU_PASS/0 whenever valid is low
//   state        : debug view of the fetch FSM
module fetch_decode
  import picomips_pkg::*;
#(
  parameter int PC_WIDTH  = 5,
  parameter int LAST_ADDR = 27
) (
  input  logic                Clock,
  input  logic                Reset,
  fetch_decode_if.master      pmem,
  input  logic                SW8,
  output logic                valid,
  output logic [PC_WIDTH-1:0] exec_addr,
  output logic [IMM_W-1:0]    imm,
  output logic                reg_sel,
  output acc_src_t            acc_src,
  output alu_op_t             alu_op,
  output logic                alu_b_imm,
  output logic                acc_we,
  output logic                reg_we,
  output logic                illegal,
  output fetch_state_t        state
);

  fetch_state_t        state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic                wait_level;
  logic                wait_level_next;
  logic [OPCODE_W-1:0] opcode;
  ctrl_t               dec_ctrl;
  logic                dec_illegal;

  function automatic logic [PC_WIDTH-1:0] next_addr(input logic [PC_WIDTH-1:0] a);
    return (a == PC_WIDTH'(LAST_ADDR)) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [PC_WIDTH-1:0] prev_addr(input logic [PC_WIDTH-1:0] a);
    return (a == '0) ? PC_WIDTH'(LAST_ADDR) : a - 1'b1;
  endfunction

  assign opcode    = pmem.Instruction[INSTR_W-1:IMM_W];
  assign imm       = pmem.Instruction[IMM_W-1:0];
  assign reg_sel   = imm[0];
  assign pmem.Addr = pc;

  instruction_decoder u_decoder (
    .opcode  (opcode),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= FILL;
      pc         <= '0;
      wait_level <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      wait_level <= wait_level_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    wait_level_next = wait_level;
    valid           = 1'b0;
    case (state)
      FILL: begin
        // Address 0 was presented during reset/FILL; its word arrives next
        // cycle, so the fetch pointer moves one ahead.
        pc_next    = PC_WIDTH'(1);
        state_next = RUN;
      end
      RUN: begin
        valid = 1'b1;
        if (opcode == OP_HEI && SW8 == imm[0]) begin
          // Hold pc: the successor word is already fetched and will be
          // re-read from the held address when the wait ends.
          state_next      = WAIT;
          wait_level_next = imm[0];
        end else begin
          pc_next = next_addr(pc);
        end
      end
      WAIT: begin
        if (SW8 != wait_level) begin
          pc_next    = next_addr(pc);
          state_next = RUN;
        end
      end
      default: begin
        state_next = FILL;
        pc_next    = '0;
      end
    endcase
  end

  // The executing word was fetched from the address one behind pc.
  assign exec_addr = (state == FILL) ? '0 : prev_addr(pc);

  assign acc_src   = valid ? dec_ctrl.acc_src   : SRC_SW;
  assign alu_op    = valid ? dec_ctrl.alu_op    : ALU_PASS;
  assign alu_b_imm = valid & dec_ctrl.alu_b_imm;
  assign acc_we    = valid & dec_ctrl.acc_we;
  assign reg_we    = valid & dec_ctrl.reg_we;
  assign illegal   = valid & dec_illegal;

endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: self-checking bench for fetch_decode with a 1-cycle ROM
// model holding the production program and a behavioural program-flow model.
module tb_fetch_decode;
  import picomips_pkg::*;

  localparam int PW   = 5;
  localparam int NW   = 28;
  localparam int LAST = 27;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset = 1'b1;
  logic SW8   = 1'b1;

  // ---------------- DUT ----------------
  fetch_decode_if #(.PC_WIDTH(PW)) pmem ();

  logic          valid;
  logic [PW-1:0] exec_addr;
  logic [3:0]    imm;
  logic          reg_sel;
  acc_src_t      acc_src;
  alu_op_t       alu_op;
  logic          alu_b_imm;
  logic          acc_we;
  logic          reg_we;
  logic          illegal;
  fetch_state_t  state;

  fetch_decode #(.PC_WIDTH(PW), .LAST_ADDR(LAST)) u_dut (
    .Clock     (clk),
    .Reset     (Reset),
    .pmem      (pmem),
    .SW8       (SW8),
    .valid     (valid),
    .exec_addr (exec_addr),
    .imm       (imm),
    .reg_sel   (reg_sel),
    .acc_src   (acc_src),
    .alu_op    (alu_op),
    .alu_b_imm (alu_b_imm),
    .acc_we    (acc_we),
    .reg_we    (reg_we),
    .illegal   (illegal),
    .state     (state)
  );

  // ---------------- ROM model ----------------
  logic [9:0] rom [0:NW-1];
  logic [9:0] rom_q = '0;
  always @(posedge clk) rom_q <= rom[pmem.Addr];
  assign pmem.Instruction = rom_q;

  function automatic logic [9:0] w(input logic [5:0] op, input logic [3:0] im);
    return {op, im};
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct packed {
    logic [1:0] src;
    logic [1:0] op;
    logic       b_imm;
    logic       awe;
    logic       rwe;
    logic       ill;
  } exp_dec_t;

  function automatic exp_dec_t decode_ref(input logic [5:0] op);
    exp_dec_t d;
    case (op)
      OP_LS:   d = '{SRC_SW,  ALU_PASS, 1'b0, 1'b1, 1'b0, 1'b0};
      OP_LR:   d = '{SRC_REG, ALU_PASS, 1'b0, 1'b1, 1'b0, 1'b0};
      OP_AR:   d = '{SRC_SW,  ALU_PASS, 1'b0, 1'b0, 1'b1, 1'b0};
      OP_ADDI: d = '{SRC_ALU, ALU_ADD,  1'b1, 1'b1, 1'b0, 1'b0};
      OP_ADDR: d = '{SRC_ALU, ALU_ADD,  1'b0, 1'b1, 1'b0, 1'b0};
      OP_MULI: d = '{SRC_ALU, ALU_MUL,  1'b1, 1'b1, 1'b0, 1'b0};
      OP_HEI:  d = '{SRC_SW,  ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b0};
      default: d = '{SRC_SW,  ALU_PASS, 1'b0, 1'b0, 1'b0, 1'b1};
    endcase
    return d;
  endfunction

  // Program flow: which address executes, whether we are in the post-reset
  // bubble, or parked on a wait instruction.
  bit m_known  = 0;
  bit m_bubble = 0;
  bit m_parked = 0;
  bit m_lvl    = 0;
  int m_exec   = 0;

  always @(posedge clk) begin
    if (Reset) begin
      m_known  = 1;
      m_bubble = 1;
      m_parked = 0;
    end else if (m_known) begin
      if (m_bubble) begin
        m_bubble = 0;
        m_exec   = 0;
      end else if (m_parked) begin
        if (SW8 != m_lvl) begin
          m_parked = 0;
          m_exec   = (m_exec + 1) % NW;
        end
      end else if (rom[m_exec][9:4] == OP_HEI && SW8 == rom[m_exec][0]) begin
        m_parked = 1;
        m_lvl    = rom[m_exec][0];
      end else begin
        m_exec = (m_exec + 1) % NW;
      end
    end
  end

  // Compare process: every cycle once the reference is known.
  always @(negedge clk) begin
    if (m_known) begin
      exp_dec_t d;
      bit       ev;
      ev = !m_bubble && !m_parked;
      chk("valid", valid, ev);
      chk("addr", pmem.Addr, m_bubble ? 0 : (m_exec + 1) % NW);
      if (ev) begin
        d = decode_ref(rom[m_exec][9:4]);
        chk("exec_addr", exec_addr, m_exec);
        chk("imm", imm, rom[m_exec][3:0]);
        chk("reg_sel", reg_sel, rom[m_exec][0]);
        chk("acc_src", acc_src, d.src);
        chk("alu_op", alu_op, d.op);
        chk("alu_b_imm", alu_b_imm, d.b_imm);
        chk("acc_we", acc_we, d.awe);
        chk("reg_we", reg_we, d.rwe);
        chk("illegal", illegal, d.ill);
      end else begin
        chk("idle_acc_we", acc_we, 0);
        chk("idle_reg_we", reg_we, 0);
        chk("idle_illegal", illegal, 0);
        chk("idle_acc_src", acc_src, SRC_SW);
        chk("idle_alu_op", alu_op, ALU_PASS);
        chk("idle_alu_b_imm", alu_b_imm, 0);
        if (m_bubble) chk("bubble_exec_addr", exec_addr, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic sw);
    @(posedge clk);
    #1;
    Reset = rst;
    SW8   = sw;
  endtask

  task automatic wait_exec(input int a, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(valid === 1'b1 && exec_addr == PW'(a)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_exec_in_budget", n < budget, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rom = '{
      w(OP_HEI, 4'h0), w(OP_LS, 4'h0),   w(OP_ADDI, 4'h3), w(OP_ADDR, 4'h1),
      w(OP_LR, 4'h0),  w(OP_MULI, 4'hE), w(OP_AR, 4'h1),   w(OP_HEI, 4'h1),
      w(OP_LS, 4'h0),  w(OP_AR, 4'h0),   w(OP_HEI, 4'h0),  w(OP_LR, 4'h1),
      w(OP_ADDR, 4'h0), w(OP_MULI, 4'h5), w(OP_AR, 4'h1),  w(OP_ADDI, 4'hF),
      w(OP_HEI, 4'h1), w(OP_LR, 4'h0),   w(OP_MULI, 4'h8), w(OP_AR, 4'h0),
      w(OP_ADDI, 4'h1), w(OP_ADDR, 4'h1), w(OP_LS, 4'h0),  w(OP_HEI, 4'h0),
      w(OP_LR, 4'h1),  w(OP_ADDI, 4'h7), w(OP_AR, 4'h1),   w(OP_MULI, 4'h2)
    };

    // 1: reset, then run from 0 with SW8=1 until HEI 1 at address 7.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", pmem.Addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_exec_addr", exec_addr, 0);
    drive(1'b0, 1'b1);
    @(negedge clk);
    chk("fill_valid", valid, 0);
    @(negedge clk);
    chk("first_valid", valid, 1);
    chk("first_exec", exec_addr, 0);
    chk("first_addr", pmem.Addr, 1);
    @(negedge clk);
    chk("second_exec", exec_addr, 1);
    chk("second_addr", pmem.Addr, 2);
    wait_exec(7, 20);
    @(negedge clk);
    chk("hei1_stall_valid", valid, 0);
    chk("hei1_stall_addr", pmem.Addr, 8);

    // 6: reset while parked, with a simultaneous SW8 release.
    drive(1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("wait_rst_addr", pmem.Addr, 0);
    chk("wait_rst_valid", valid, 0);
    drive(1'b0, 1'b0);
    @(negedge clk);
    chk("wait_rst_fill", valid, 0);
    @(negedge clk);
    chk("resume_valid", valid, 1);
    chk("resume_exec", exec_addr, 0);

    // 2: SW8=0 at HEI 0 parks with Addr=1; release after 10 cycles.
    @(negedge clk);
    chk("hei0_stall_valid", valid, 0);
    chk("hei0_stall_addr", pmem.Addr, 1);
    repeat (10) @(negedge clk);
    chk("hei0_held_addr", pmem.Addr, 1);
    drive(1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("release_valid", valid, 1);
    chk("release_exec", exec_addr, 1);
    chk("release_acc_we", acc_we, 1);
    chk("release_acc_src", acc_src, SRC_SW);

    // 3: MULI at 5 and AR at 6.
    wait_exec(5, 20);
    chk("muli_alu_op", alu_op, ALU_MUL);
    chk("muli_b_imm", alu_b_imm, 1);
    chk("muli_imm", imm, 4'hE);
    chk("muli_acc_we", acc_we, 1);
    chk("muli_reg_we", reg_we, 0);
    @(negedge clk);
    chk("ar_exec", exec_addr, 6);
    chk("ar_reg_we", reg_we, 1);
    chk("ar_reg_sel", reg_sel, 1);

    // 4: toggle SW8 randomly until 26 executes, then expect 27, 0 back to back.
    begin
      int n;
      n = 0;
      while (!(valid === 1'b1 && exec_addr == PW'(26)) && n < 400) begin
        drive(1'b0, 1'($urandom_range(0, 1)));
        @(negedge clk);
        n++;
      end
      chk("wrap_in_budget", n < 400, 1);
    end
    chk("wrap_addr_26", pmem.Addr, 27);
    @(negedge clk);
    chk("wrap_exec_27", exec_addr, 27);
    chk("wrap_valid_27", valid, 1);
    chk("wrap_addr_27", pmem.Addr, 0);
    @(negedge clk);
    chk("wrap_exec_0", exec_addr, 0);
    chk("wrap_valid_0", valid, 1);
    chk("wrap_addr_0", pmem.Addr, 1);

    // 5: illegal opcode injected at address 3 (changed only under reset).
    drive(1'b1, 1'b1);
    rom[3] = w(6'h2A, 4'h5);
    drive(1'b0, 1'b1);
    wait_exec(3, 20);
    chk("ill_illegal", illegal, 1);
    chk("ill_valid", valid, 1);
    chk("ill_acc_we", acc_we, 0);
    chk("ill_reg_we", reg_we, 0);
    @(negedge clk);
    chk("ill_next_exec", exec_addr, 4);
    chk("ill_next_valid", valid, 1);

    // Random run: SW8 toggles and occasional resets.
    drive(1'b1, 1'b1);
    rom[3] = w(OP_ADDR, 4'h1);
    for (int i = 0; i < 3000; i++) begin
      logic sw;
      sw = SW8;
      if ($urandom_range(0, 3) == 0) sw = ~sw;
      drive(1'($urandom_range(0, 99) == 0), sw);
    end
    drive(1'b0, SW8);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
